pacoblaze_pc_sequencer: RTL

- Program-counter and call/return sequencer for the PacoBlaze core.
- Initiator side of the call/return stack interface. Issues push/pop strobes and return addresses to the single-port stack RAM, and consumes the popped address.
- Tracks stack occupancy and flags overflow/underflow. Handles interrupt entry (push + vector) and RETURNI.
- Sits between the instruction decoder and the stack; drives the instruction ROM address.

---
 rtl/pacoblaze_pc_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/pacoblaze_pc_sequencer.sv
// rtl/pacoblaze_pc_sequencer.sv - PacoBlaze program counter and call/return stack sequencer
// Two-phase FETCH/EXEC engine that drives the ROM address and the stack push/pop strobes.
module pacoblaze_pc_sequencer #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    STACK_DEPTH = 5,
  parameter int                    STACK_SIZE  = 31,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR  = 10'h3FF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   jump,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   returni,
  input  logic                   cond,
  input  logic [ADDR_WIDTH-1:0]  target,
  input  logic                   irq_take,
  input  logic [ADDR_WIDTH-1:0]  stack_q,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   exec,
  output logic                   stack_we,
  output logic                   stack_upd,
  output logic                   stack_push,
  output logic [ADDR_WIDTH-1:0]  stack_d,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   overflow,
  output logic                   underflow
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [STACK_DEPTH-1:0] FULL = STACK_DEPTH'(STACK_SIZE);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic                    do_push;
  logic                    do_pop;
  logic                    active;

  assign active = enable && (state == EXEC);

  always_comb begin
    state_next = state;
    if (enable) begin
      state_next = (state == FETCH) ? EXEC : FETCH;
    end
  end

  // Decode priority: interrupt entry beats every decoded control-flow instruction.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    pc_next = pc + ADDR_WIDTH'(1);
    if (irq_take) begin
      do_push = 1'b1;
      pc_next = INT_VECTOR;
    end else if (returni) begin
      do_pop  = 1'b1;
      pc_next = stack_q;
    end else if (call && cond) begin
      do_push = 1'b1;
      pc_next = target;
    end else if (ret && cond) begin
      do_pop  = 1'b1;
      pc_next = stack_q + ADDR_WIDTH'(1);
    end else if (jump && cond) begin
      pc_next = target;
    end
  end

  // Strobes are issued even at full/empty so the external stack pointer wraps like the hardware.
  assign stack_we   = active && do_push;
  assign stack_upd  = active && (do_push || do_pop);
  assign stack_push = active && do_push;
  assign stack_d    = pc;
  assign address    = pc;
  assign exec       = (state == EXEC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (active) begin
      pc <= pc_next;
      if (do_push) begin
        if (depth == FULL) begin
          overflow <= 1'b1;
        end else begin
          depth <= depth + STACK_DEPTH'(1);
        end
      end else if (do_pop) begin
        if (depth == '0) begin
          underflow <= 1'b1;
        end else begin
          depth <= depth - STACK_DEPTH'(1);
        end
      end
    end
  end

endmodule
